// File: rtl/i2c_pkg.sv
// Shared constants and bit-order helpers for the I2C target receiver.
package i2c_pkg;

  localparam int unsigned ByteW = 8;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_RW_WRITE = 1'b0;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAddr    = 3'd1;
  localparam logic [2:0] StAddrAck = 3'd2;
  localparam logic [2:0] StData    = 3'd3;
  localparam logic [2:0] StDataAck = 3'd4;
  localparam logic [2:0] StIgnore  = 3'd5;

  // LSB-first shifts right so the first bit on the wire lands in bit 0.
  function automatic logic [ByteW-1:0] shift_in(input logic [ByteW-1:0] cur,
                                                 input logic           b,
                                                 input logic           msb_first);
    if (msb_first) begin
      return {cur[ByteW-2:0], b};
    end
    return {b, cur[ByteW-1:1]};
  endfunction

  function automatic logic [6:0] addr_of(input logic [ByteW-1:0] b, input logic msb_first);
    return msb_first ? b[7:1] : b[6:0];
  endfunction

  // R/W is always the last bit of the address phase.
  function automatic logic rw_of(input logic [ByteW-1:0] b, input logic msb_first);
    return msb_first ? b[0] : b[7];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser and line-event detector; I2C_RX_GLITCH_FILTER_EN adds a
// 3-sample majority filter (+2 clk) after the synchroniser.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s_o,
  output logic sda_s_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_lvl, sda_lvl;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s_q, sda_s_q;
  logic                   scl_rise_q, scl_fall_q, start_q, stop_q;

  // Reset to an idle (high) bus so release of reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

`ifdef I2C_RX_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_flt_q, sda_flt_q;
  logic       scl_new, sda_new;

  assign scl_new = scl_sync_q[SYNC_STAGES-1];
  assign sda_new = sda_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_new};
      sda_hist_q <= {sda_hist_q[0], sda_new};
      scl_flt_q  <= (scl_new & scl_hist_q[0]) | (scl_new & scl_hist_q[1]) |
                    (scl_hist_q[0] & scl_hist_q[1]);
      sda_flt_q  <= (sda_new & sda_hist_q[0]) | (sda_new & sda_hist_q[1]) |
                    (sda_hist_q[0] & sda_hist_q[1]);
    end
  end

  assign scl_lvl = scl_flt_q;
  assign sda_lvl = sda_flt_q;
`else
  assign scl_lvl = scl_sync_q[SYNC_STAGES-1];
  assign sda_lvl = sda_sync_q[SYNC_STAGES-1];
`endif

  // Events are registered together with the levels so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_s_q    <= 1'b1;
      sda_s_q    <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_prev_q <= scl_lvl;
      sda_prev_q <= sda_lvl;
      scl_s_q    <= scl_lvl;
      sda_s_q    <= sda_lvl;
      scl_rise_q <= scl_lvl & ~scl_prev_q;
      scl_fall_q <= ~scl_lvl & scl_prev_q;
      start_q    <= scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
      stop_q     <= scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;
    end
  end

  assign scl_s_o    = scl_s_q;
  assign sda_s_o    = sda_s_q;
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: address match, ACK generation and data byte capture.
// Optional line glitch filter is enabled by defining I2C_RX_GLITCH_FILTER_EN.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          MSB_FIRST   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic [6:0]       own_addr,
  output logic [ByteW-1:0] rx_data,
  output logic             rx_valid,
  output logic             addr_match,
  output logic             busy
);

  logic scl_s, sda_s, scl_rise, scl_fall, start, stop;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_s_o    (scl_s),
    .sda_s_o    (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  logic [2:0]       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             byte_done_q, byte_done_d;
  logic [ByteW-1:0] shift_q, shift_d;
  logic [6:0]       own_addr_q, own_addr_d;
  logic             sda_oe_q, sda_oe_d;
  logic [ByteW-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             addr_match_q, addr_match_d;
  logic             busy_q, busy_d;
  logic [ByteW-1:0] shifted;
  logic             addr_ok;

  assign shifted = shift_in(shift_q, sda_s, MSB_FIRST);
  assign addr_ok = (addr_of(shift_q, MSB_FIRST) == own_addr_q) &&
                   (rw_of(shift_q, MSB_FIRST) == I2C_RW_WRITE);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_done_d  = byte_done_q;
    shift_d      = shift_q;
    own_addr_d   = own_addr_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    addr_match_d = addr_match_q;
    busy_d       = busy_q;

    if (start) begin
      state_d      = StAddr;
      busy_d       = 1'b1;
      bit_cnt_d    = 3'd0;
      byte_done_d  = 1'b0;
      addr_match_d = 1'b0;
      sda_oe_d     = 1'b0;
      own_addr_d   = own_addr;
    end else if (stop) begin
      state_d      = StIdle;
      busy_d       = 1'b0;
      bit_cnt_d    = 3'd0;
      byte_done_d  = 1'b0;
      addr_match_d = 1'b0;
      sda_oe_d     = 1'b0;
    end else begin
      case (state_q)
        StAddr, StData: begin
          if (scl_rise && !byte_done_q) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              if (state_q == StData) begin
                rx_data_d  = shifted;
                rx_valid_d = 1'b1;
              end
            end
          end else if (scl_fall && byte_done_q) begin
            // ACK slot begins on the falling edge after the 8th bit.
            byte_done_d = 1'b0;
            if (state_q == StData) begin
              sda_oe_d = ~I2C_ACK;
              state_d  = StDataAck;
            end else if (addr_ok) begin
              sda_oe_d     = ~I2C_ACK;
              addr_match_d = 1'b1;
              state_d      = StAddrAck;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StAddrAck, StDataAck: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = StData;
          end
        end
        StIgnore: begin
          sda_oe_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      byte_done_q  <= 1'b0;
      shift_q      <= '0;
      own_addr_q   <= '0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_done_q  <= byte_done_d;
      shift_q      <= shift_d;
      own_addr_q   <= own_addr_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;

endmodule
